rr_mux_scheduler: RTL
=====================

// Module: rr_mux_scheduler
// PURPOSE
//   Upstream select stage for the 4:1 width-parametric multiplexer. Arbitrates
//   four request channels round-robin and drives the 2-bit mux select.
//   Captures the winning channel's data and presents it downstream through a
//   valid/ready handshake. Acks the winning requester with a one-cycle pulse.
// PARAMETERS
//   width  4  data width of each channel and of the output
// PORTS
//   clk      in   1      clock, all state updates on rising edge
//   rst_b    in   1      reset, synchronous, active-low
//   req      in   4      req[i]=1: channel i has data on di
//   d0..d3   in   width  channel data; di must be stable while req[i]=1
//   ack      out  4      one-hot pulse, ack[i]=1 one cycle after di captured
//   s        out  2      select of the granted channel (00->d0 .. 11->d3)
//   o_valid  out  1      o holds a captured word
//   o_ready  in   1      downstream accepts o when o_valid=1 and o_ready=1
//   o        out  width  captured data word
// BEHAVIOUR
//   - Reset (rst_b=0 at a clk edge): state=IDLE, ptr=2'b11, s=2'b00,
//     o={width{1'b0}}, o_valid=0, ack=4'b0000. Applies in any state and
//     overrides every other input; a word held mid-transfer is discarded.
//   - FSM with 2 states, IDLE and HOLD.
//   - IDLE, req==0: stay in IDLE, outputs unchanged except ack=0.
//   - IDLE, req!=0: winner = first set req bit scanning ptr+1, ptr+2,
//     ptr+3, ptr (mod 4). At the edge: s<=winner, o<=d[winner],
//     o_valid<=1, ack<=one-hot(winner), ptr<=winner, state<=HOLD.
//   - HOLD: ack=0 after the first HOLD cycle (pulse width exactly 1).
//     o, s and o_valid stay stable until the handshake.
//   - HOLD, o_valid & o_ready at an edge: o_valid<=0, state<=IDLE.
//     o and s keep their last value.
//   - HOLD, o_ready=0: stay in HOLD indefinitely; req changes are ignored.
//   - Capture latency: req to o_valid is 1 cycle.
//   - Maximum throughput: one word per 2 cycles, with a mandatory IDLE
//     bubble. The requester drops req on the edge ending its ack, so IDLE
//     always samples the updated req.
//   - Handshake in the first HOLD cycle (ack=1 and accept together) is legal.
//     Next cycle is IDLE with ack=0.
//   - Fairness: a channel that keeps req high waits at most 3 grants.
//   - Wrap-around: ptr=3 scans 0,1,2,3. After reset the first scan starts
//     at channel 0.
//   - req bits not one-hot: only the winner is acked; the others keep
//     waiting.
//   - o_ready while o_valid=0: ignored.
// TESTING
//   1 Reset: hold rst_b=0 for 2 edges with req=4'hF ->
//     o_valid=0, ack=0, s=00, o=0.
//   2 Single channel: req=4'b0100, d2=4'h4, o_ready=1 ->
//     next cycle s=10, o=4'h4, o_valid=1, ack=4'b0100; o_valid=0 one
//     cycle later.
//   3 Round-robin: req=4'hF held, d0..d3=1,2,4,8, o_ready=1 ->
//     grant order 0,1,2,3,0; o=1,2,4,8,1 every 2nd cycle.
//   4 Backpressure: o_ready=0 for 5 cycles after capture of d1=4'h2 ->
//     o=4'h2 and s=01 stable, o_valid=1, ack high only in cycle 1;
//     o_ready=1 -> o_valid=0 next edge.
//   5 Wrap and skip: after a grant to ch3, req=4'b1010 -> ch1 wins,
//     then ch3 wins.
//   6 Reset mid-HOLD: rst_b=0 while o_valid=1 ->
//     o_valid=0, state=IDLE, ptr=3; next grant with req=4'hF goes to ch0.

Source files
------------

// File: rtl/rr_mux_scheduler.sv
// Round-robin 4:1 select stage: arbitrates four request channels, captures the
// winning channel's word and presents it downstream via valid/ready. The winner
// receives a single-cycle ack pulse in the first cycle after capture.
module rr_mux_scheduler #(
   parameter int unsigned width = 4
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [3:0]       req,
   input  logic [width-1:0] d0,
   input  logic [width-1:0] d1,
   input  logic [width-1:0] d2,
   input  logic [width-1:0] d3,
   output logic [3:0]       ack,
   output logic [1:0]       s,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [width-1:0] o
);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e             state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [1:0]         s_q, s_d;
   logic [width-1:0]   o_q, o_d;
   logic               o_valid_q, o_valid_d;
   logic [3:0]         ack_q, ack_d;

   logic               win_found;
   logic [1:0]         winner;
   logic [width-1:0]   win_data;

   // Rotating priority scan: ptr+1 first, ptr itself last.
   always_comb begin
      win_found = 1'b0;
      winner    = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         logic [1:0] idx;
         idx = ptr_q + k[1:0];
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            winner    = idx;
         end
      end
   end

   // Data mux driven by the arbitration result.
   always_comb begin
      win_data = d0;
      unique case (winner)
         2'd0: win_data = d0;
         2'd1: win_data = d1;
         2'd2: win_data = d2;
         2'd3: win_data = d3;
         default: win_data = d0;
      endcase
   end

   // Next-state and output-register logic; ack is cleared every cycle it is
   // not being set, which yields an exactly one-cycle pulse.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      s_d       = s_q;
      o_d       = o_q;
      o_valid_d = o_valid_q;
      ack_d     = 4'b0000;
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               s_d       = winner;
               o_d       = win_data;
               o_valid_d = 1'b1;
               ack_d     = 4'b0001 << winner;
               ptr_d     = winner;
               state_d   = StHold;
            end
         end
         StHold: begin
            // Requests are ignored here; only the handshake ends the hold.
            if (o_valid_q && o_ready) begin
               o_valid_d = 1'b0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset; ptr resets to 3 so the
   // first scan after reset begins at channel 0.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q   <= StIdle;
         ptr_q     <= 2'b11;
         s_q       <= 2'b00;
         o_q       <= '0;
         o_valid_q <= 1'b0;
         ack_q     <= 4'b0000;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         s_q       <= s_d;
         o_q       <= o_d;
         o_valid_q <= o_valid_d;
         ack_q     <= ack_d;
      end
   end

   assign ack     = ack_q;
   assign s       = s_q;
   assign o       = o_q;
   assign o_valid = o_valid_q;

endmodule
